tmr_voter_rollback: RTL and testbench

Parametrised triple-modular-redundancy commit voter with a multi-entry rollback history. It sits between the three RISC-V core replicas and shared memory/PC feedback. It votes PC plus NUM_FIELDS data fields 2-of-3 and tracks per-replica fault counts. On total disagreement it runs a rollback/recovery state machine with a retry limit, then declares fatal error.

---
 rtl/tmr_pkg.sv | 22 ++
 rtl/pc_history_buf.sv | 63 ++++++
 rtl/tmr_voter_rollback.sv | 215 +++++++++++++++++++++
 tb/tb_tmr_voter_rollback.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared types and index constants for the TMR commit voter.
// Pair and replica indices give bit positions in voter_state and fault_flag.
package tmr_pkg;

  typedef enum logic [1:0] {
    StNormal,
    StRollback,
    StHold,
    StFatal
  } tmr_state_e;

  // Bit positions inside voter_state = {AB, BC, AC}
  localparam int unsigned PairAb = 2;
  localparam int unsigned PairBc = 1;
  localparam int unsigned PairAc = 0;

  // Bit positions inside fault_flag = {A, B, C}
  localparam int unsigned RepA = 2;
  localparam int unsigned RepB = 1;
  localparam int unsigned RepC = 0;

endpackage

// File: rtl/pc_history_buf.sv
// Circular history of committed PCs. The oldest entry is the rollback target;
// collapse keeps only that entry so repeated rollbacks return to the same point.
module pc_history_buf #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned HIST_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              collapse_i,
  output logic [DATA_W-1:0] oldest_o,
  output logic              empty_o
);

  localparam int unsigned PtrW = $clog2(HIST_DEPTH);
  localparam int unsigned CntW = $clog2(HIST_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [HIST_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   oldest_idx;
  logic              do_write;

  // When full the truncated count is zero, so the oldest slot is wr_ptr itself.
  assign oldest_idx = wr_ptr_q - PtrW'(count_q);
  assign oldest_o   = mem_q[oldest_idx];
  assign empty_o    = (count_q == '0);
  assign do_write   = push_i && !collapse_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (collapse_i) begin
      if (count_q != '0) begin
        wr_ptr_d = oldest_idx + PtrW'(1);
        count_d  = CntW'(1);
      end
    end else if (push_i) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (count_q != CntW'(HIST_DEPTH)) begin
        count_d = count_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/tmr_voter_rollback.sv
// 2-of-3 commit voter for triplicated cores with per-replica fault counting
// and a bounded rollback/hold recovery sequence ending in a sticky fatal state.
module tmr_voter_rollback
  import tmr_pkg::*;
#(
  parameter int unsigned       DATA_W          = 32,
  parameter int unsigned       NUM_FIELDS      = 3,
  parameter int unsigned       HIST_DEPTH      = 4,
  parameter int unsigned       RECOVERY_CYCLES = 3,
  parameter int unsigned       FAULT_THRESH    = 8,
  parameter int unsigned       MAX_RETRY       = 3,
  parameter logic [DATA_W-1:0] RESET_PC        = '0
) (
  input  logic                         clk,
  input  logic                         rst_in,
  input  logic                         valid_in,
  input  logic [DATA_W-1:0]            pc_a,
  input  logic [DATA_W-1:0]            pc_b,
  input  logic [DATA_W-1:0]            pc_c,
  input  logic [NUM_FIELDS*DATA_W-1:0] fld_a,
  input  logic [NUM_FIELDS*DATA_W-1:0] fld_b,
  input  logic [NUM_FIELDS*DATA_W-1:0] fld_c,
  output logic [DATA_W-1:0]            pc_out,
  output logic [NUM_FIELDS*DATA_W-1:0] fld_out,
  output logic                         valid_out,
  output logic [2:0]                   voter_state,
  output logic                         recovery_mode,
  output logic                         rollback,
  output logic [2:0]                   fault_flag,
  output logic                         fatal
);

  localparam int unsigned FldW   = NUM_FIELDS * DATA_W;
  localparam int unsigned HoldW  = $clog2(RECOVERY_CYCLES + 1);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);
  localparam int unsigned FcntW  = $clog2(FAULT_THRESH + 1);

  tmr_state_e        state_q, state_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [FcntW-1:0]  fcnt_q [3];
  logic [FcntW-1:0]  fcnt_d [3];
  logic [2:0]        fault_flag_q, fault_flag_d;
  logic [DATA_W-1:0] pc_out_q, pc_out_d;
  logic [FldW-1:0]   fld_out_q, fld_out_d;
  logic              valid_out_q, valid_out_d;
  logic [2:0]        voter_state_q;
  logic              recovery_q, recovery_d;
  logic              rollback_q, rollback_d;
  logic              fatal_q, fatal_d;

  logic [2:0]        agree;
  logic [2:0]        odd;
  logic [DATA_W-1:0] sel_pc;
  logic [FldW-1:0]   sel_fld;
  logic              push, collapse;
  logic [DATA_W-1:0] hist_oldest;
  logic              hist_empty;

  always_comb begin
    agree         = '0;
    agree[PairAb] = (pc_a == pc_b) && (fld_a == fld_b);
    agree[PairBc] = (pc_b == pc_c) && (fld_b == fld_c);
    agree[PairAc] = (pc_a == pc_c) && (fld_a == fld_c);
  end

  always_comb begin
    sel_pc  = pc_a;
    sel_fld = fld_a;
    if (agree[PairAb]) begin
      sel_pc  = pc_a;
      sel_fld = fld_a;
    end else if (agree[PairBc]) begin
      sel_pc  = pc_b;
      sel_fld = fld_b;
    end else if (agree[PairAc]) begin
      sel_pc  = pc_c;
      sel_fld = fld_c;
    end
  end

  // A lone agreeing pair points at the replica outside it.
  always_comb begin
    odd       = '0;
    odd[RepC] = (agree == 3'(1 << PairAb));
    odd[RepA] = (agree == 3'(1 << PairBc));
    odd[RepB] = (agree == 3'(1 << PairAc));
  end

  pc_history_buf #(
    .DATA_W    (DATA_W),
    .HIST_DEPTH(HIST_DEPTH)
  ) u_hist (
    .clk_i     (clk),
    .rst_i     (rst_in),
    .push_i    (push),
    .data_i    (sel_pc),
    .collapse_i(collapse),
    .oldest_o  (hist_oldest),
    .empty_o   (hist_empty)
  );

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    retry_d      = retry_q;
    fcnt_d       = fcnt_q;
    fault_flag_d = fault_flag_q;
    pc_out_d     = pc_out_q;
    fld_out_d    = fld_out_q;
    valid_out_d  = 1'b0;
    push         = 1'b0;
    collapse     = 1'b0;

    unique case (state_q)
      StNormal: begin
        pc_out_d    = sel_pc;
        fld_out_d   = sel_fld;
        valid_out_d = valid_in;
        if (valid_in) begin
          if (agree == 3'b000) begin
            valid_out_d = 1'b0;
            fld_out_d   = fld_out_q;
            if (retry_q < RetryW'(MAX_RETRY)) begin
              state_d  = StRollback;
              retry_d  = retry_q + RetryW'(1);
              pc_out_d = hist_empty ? RESET_PC : hist_oldest;
            end else begin
              state_d  = StFatal;
              pc_out_d = RESET_PC;
            end
          end else begin
            push = 1'b1;
            if (agree == 3'b111) begin
              retry_d = '0;
            end
            for (int r = 0; r < 3; r++) begin
              if (odd[r] && (fcnt_q[r] != FcntW'(FAULT_THRESH))) begin
                fcnt_d[r] = fcnt_q[r] + FcntW'(1);
              end
              if (fcnt_d[r] == FcntW'(FAULT_THRESH)) begin
                fault_flag_d[r] = 1'b1;
              end
            end
          end
        end
      end
      StRollback: begin
        collapse   = 1'b1;
        hold_cnt_d = '0;
        state_d    = StHold;
      end
      StHold: begin
        if (hold_cnt_q == HoldW'(RECOVERY_CYCLES - 1)) begin
          state_d = StNormal;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StFatal: begin
        pc_out_d = RESET_PC;
      end
      default: begin
        state_d = StNormal;
      end
    endcase

    // Status outputs describe the state being entered, keeping them registered.
    rollback_d = (state_d == StRollback);
    recovery_d = (state_d != StNormal);
    fatal_d    = (state_d == StFatal);
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= StNormal;
      hold_cnt_q    <= '0;
      retry_q       <= '0;
      for (int r = 0; r < 3; r++) begin
        fcnt_q[r] <= '0;
      end
      fault_flag_q  <= '0;
      pc_out_q      <= RESET_PC;
      fld_out_q     <= '0;
      valid_out_q   <= 1'b0;
      voter_state_q <= 3'b111;
      recovery_q    <= 1'b0;
      rollback_q    <= 1'b0;
      fatal_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      retry_q       <= retry_d;
      fcnt_q        <= fcnt_d;
      fault_flag_q  <= fault_flag_d;
      pc_out_q      <= pc_out_d;
      fld_out_q     <= fld_out_d;
      valid_out_q   <= valid_out_d;
      voter_state_q <= agree;
      recovery_q    <= recovery_d;
      rollback_q    <= rollback_d;
      fatal_q       <= fatal_d;
    end
  end

  assign pc_out        = pc_out_q;
  assign fld_out       = fld_out_q;
  assign valid_out     = valid_out_q;
  assign voter_state   = voter_state_q;
  assign recovery_mode = recovery_q;
  assign rollback      = rollback_q;
  assign fault_flag    = fault_flag_q;
  assign fatal         = fatal_q;

endmodule

// File: tb/tb_tmr_voter_rollback.sv
// Bench for tmr_voter_rollback: directed scenarios plus random commits, all
// checked against a queue-based behavioural model of voting and recovery.
module tb_tmr_voter_rollback;

  localparam int unsigned   DW     = 32;
  localparam int unsigned   NF     = 3;
  localparam int unsigned   FW     = DW * NF;
  localparam int unsigned   DEPTH  = 4;
  localparam int unsigned   RECOV  = 3;
  localparam int unsigned   THRESH = 8;
  localparam int unsigned   MAXR   = 3;
  localparam logic [DW-1:0] RST_PC = 32'h0000_0080;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          valid_in;
  logic [DW-1:0] pc_a, pc_b, pc_c;
  logic [FW-1:0] fld_a, fld_b, fld_c;
  logic [DW-1:0] pc_out;
  logic [FW-1:0] fld_out;
  logic          valid_out;
  logic [2:0]    voter_state;
  logic          recovery_mode;
  logic          rollback;
  logic [2:0]    fault_flag;
  logic          fatal;

  always #5 clk = ~clk;

  tmr_voter_rollback #(
    .DATA_W         (DW),
    .NUM_FIELDS     (NF),
    .HIST_DEPTH     (DEPTH),
    .RECOVERY_CYCLES(RECOV),
    .FAULT_THRESH   (THRESH),
    .MAX_RETRY      (MAXR),
    .RESET_PC       (RST_PC)
  ) dut (
    .clk          (clk),
    .rst_in       (rst_in),
    .valid_in     (valid_in),
    .pc_a         (pc_a),
    .pc_b         (pc_b),
    .pc_c         (pc_c),
    .fld_a        (fld_a),
    .fld_b        (fld_b),
    .fld_c        (fld_c),
    .pc_out       (pc_out),
    .fld_out      (fld_out),
    .valid_out    (valid_out),
    .voter_state  (voter_state),
    .recovery_mode(recovery_mode),
    .rollback     (rollback),
    .fault_flag   (fault_flag),
    .fatal        (fatal)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: history as a queue (front = oldest), recovery as a countdown.
  logic [DW-1:0] hist [$];
  int            rec_left;
  bit            m_fatal;
  int            retry;
  int            fcnt [3];  // 0 = A, 1 = B, 2 = C

  logic [DW-1:0] exp_pc;
  logic [FW-1:0] exp_fld;
  logic          exp_valid, exp_rec, exp_rb, exp_fatal;
  logic [2:0]    exp_vs, exp_ff;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    rec_left  = 0;
    m_fatal   = 1'b0;
    retry     = 0;
    for (int r = 0; r < 3; r++) fcnt[r] = 0;
    exp_pc    = RST_PC;
    exp_fld   = '0;
    exp_valid = 1'b0;
    exp_vs    = 3'b111;
    exp_rec   = 1'b0;
    exp_rb    = 1'b0;
    exp_ff    = 3'b000;
    exp_fatal = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [DW-1:0] pa, input logic [DW-1:0] pb,
                            input logic [DW-1:0] pc, input logic [FW-1:0] fa,
                            input logic [FW-1:0] fb, input logic [FW-1:0] fc);
    bit            ab, bc, ac;
    logic [DW-1:0] spc;
    logic [FW-1:0] sfld;
    logic [DW-1:0] tgt;
    ab = (pa == pb) && (fa == fb);
    bc = (pb == pc) && (fb == fc);
    ac = (pa == pc) && (fa == fc);
    exp_vs = {ab, bc, ac};
    if (ab) begin spc = pa; sfld = fa; end
    else if (bc) begin spc = pb; sfld = fb; end
    else if (ac) begin spc = pc; sfld = fc; end
    else begin spc = pa; sfld = fa; end
    exp_rb    = 1'b0;
    exp_valid = 1'b0;
    if (m_fatal) begin
      exp_pc = RST_PC;
    end else if (rec_left > 0) begin
      if (rec_left == int'(RECOV) + 1 && hist.size() > 0) begin
        tgt = hist[0];
        hist.delete();
        hist.push_back(tgt);
      end
      rec_left--;
    end else begin
      exp_pc    = spc;
      exp_fld   = sfld;
      exp_valid = v;
      if (v) begin
        if (!ab && !bc && !ac) begin
          exp_valid = 1'b0;
          if (retry < int'(MAXR)) begin
            retry++;
            rec_left = int'(RECOV) + 1;
            exp_rb   = 1'b1;
            if (hist.size() > 0) exp_pc = hist[0];
            else exp_pc = RST_PC;
          end else begin
            m_fatal = 1'b1;
            exp_pc  = RST_PC;
          end
        end else begin
          hist.push_back(spc);
          if (hist.size() > int'(DEPTH)) void'(hist.pop_front());
          if (ab && bc && ac) retry = 0;
          else if (ab) fcnt[2]++;
          else if (bc) fcnt[0]++;
          else fcnt[1]++;
        end
      end
    end
    exp_rec   = m_fatal || (rec_left > 0);
    exp_fatal = m_fatal;
    exp_ff    = {fcnt[0] >= int'(THRESH), fcnt[1] >= int'(THRESH), fcnt[2] >= int'(THRESH)};
  endtask

  task automatic compare_all();
    check_eq("valid_out", 128'(valid_out), 128'(exp_valid));
    check_eq("voter_state", 128'(voter_state), 128'(exp_vs));
    check_eq("recovery_mode", 128'(recovery_mode), 128'(exp_rec));
    check_eq("rollback", 128'(rollback), 128'(exp_rb));
    check_eq("fault_flag", 128'(fault_flag), 128'(exp_ff));
    check_eq("fatal", 128'(fatal), 128'(exp_fatal));
    if (exp_valid || exp_rec) check_eq("pc_out", 128'(pc_out), 128'(exp_pc));
    if (exp_valid) check_eq("fld_out", 128'(fld_out), 128'(exp_fld));
  endtask

  // Called at a falling edge; applies inputs and checks one cycle later.
  task automatic step(input logic v, input logic [DW-1:0] pa, input logic [DW-1:0] pb,
                      input logic [DW-1:0] pc, input logic [FW-1:0] fa,
                      input logic [FW-1:0] fb, input logic [FW-1:0] fc);
    valid_in = v;
    pc_a = pa; pc_b = pb; pc_c = pc;
    fld_a = fa; fld_b = fb; fld_c = fc;
    model_step(v, pa, pb, pc, fa, fb, fc);
    @(negedge clk);
    compare_all();
  endtask

  task automatic clean(input logic [DW-1:0] p);
    logic [FW-1:0] f;
    f = {$urandom, $urandom, $urandom};
    step(1'b1, p, p, p, f, f, f);
  endtask

  task automatic split();
    logic [FW-1:0] f;
    f = {$urandom, $urandom, $urandom};
    step(1'b1, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000, f, f, f);
  endtask

  task automatic do_reset();
    rst_in   = 1'b1;
    valid_in = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_eq("rst_pc", 128'(pc_out), 128'(RST_PC));
    check_eq("rst_fld", 128'(fld_out), 128'(0));
    @(negedge clk);
    rst_in = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] p;
    logic [FW-1:0] f;
    logic [DW-1:0] rp [3];
    logic [FW-1:0] rf [3];
    int            mode;
    int            first;

    rst_in = 1'b1; valid_in = 1'b0;
    pc_a = '0; pc_b = '0; pc_c = '0;
    fld_a = '0; fld_b = '0; fld_c = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // All replicas agree
    for (int i = 0; i < 3; i++) begin
      p = DW'(i * 4);
      clean(p);
      check_eq("t1_pc", 128'(pc_out), 128'(p));
      check_eq("t1_vs", 128'(voter_state), 128'(3'b111));
    end

    // Replica C field 1 corrupted: masked, flagged after the threshold
    for (int i = 0; i < int'(THRESH); i++) begin
      f = {$urandom, $urandom, $urandom};
      p = DW'(32'h100 + i * 4);
      step(1'b1, p, p, p, f, f, f ^ (FW'(1) << (DW + 3)));
      check_eq("t2_pc", 128'(pc_out), 128'(p));
    end
    check_eq("t2_flag", 128'(fault_flag), 128'(3'b001));
    check_eq("t2_vs", 128'(voter_state), 128'(3'b100));
    check_eq("t2_norb", 128'(rollback), 128'(0));

    // Rollback to the oldest of a full history, then again after collapse
    do_reset();
    for (int i = 0; i < 5; i++) clean(DW'(32'h10 + i * 4));
    split();
    check_eq("t3_rb", 128'(rollback), 128'(1));
    check_eq("t3_target", 128'(pc_out), 128'(32'h14));
    for (int i = 0; i < int'(RECOV) + 1; i++) clean(DW'(32'h30 + i * 4));
    check_eq("t3_norm", 128'(recovery_mode), 128'(0));
    clean(32'h40);
    check_eq("t3_resume", 128'(pc_out), 128'(32'h40));
    split();
    check_eq("t3_target2", 128'(pc_out), 128'(32'h14));
    for (int i = 0; i < int'(RECOV) + 1; i++) clean(32'h50);

    // Retry limit exhausted leads to sticky fatal
    do_reset();
    for (int k = 0; k <= int'(MAXR); k++) begin
      split();
      if (k < int'(MAXR)) begin
        check_eq("t4_rb", 128'(rollback), 128'(1));
        for (int i = 0; i < int'(RECOV) + 1; i++) clean(32'h60);
      end
    end
    check_eq("t4_fatal", 128'(fatal), 128'(1));
    check_eq("t4_pc", 128'(pc_out), 128'(RST_PC));
    for (int i = 0; i < 3; i++) clean(32'h70);
    check_eq("t4_sticky", 128'(fatal), 128'(1));
    check_eq("t4_novalid", 128'(valid_out), 128'(0));

    // Disagreement on the first commit targets the reset PC
    do_reset();
    split();
    check_eq("t5_target", 128'(pc_out), 128'(RST_PC));
    check_eq("t5_rb", 128'(rollback), 128'(1));
    for (int i = 0; i < int'(RECOV) + 1; i++) clean(32'h90);

    // Reset in the middle of HOLD
    do_reset();
    clean(32'h200);
    clean(32'h204);
    split();
    clean(32'h208);
    clean(32'h20c);
    check_eq("t6_inhold", 128'(recovery_mode), 128'(1));
    do_reset();
    clean(32'h300);
    check_eq("t6_pc", 128'(pc_out), 128'(32'h300));
    check_eq("t6_valid", 128'(valid_out), 128'(1));

    // Random commits with occasional faults and resets
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        p = $urandom;
        f = {$urandom, $urandom, $urandom};
        for (int r = 0; r < 3; r++) begin
          rp[r] = p;
          rf[r] = f;
        end
        mode = int'($urandom_range(0, 19));
        first = int'($urandom_range(0, 2));
        if (mode >= 12) begin
          // 12..17: one bad replica, 18: two bad, 19: all three perturbed
          for (int j = 0; j < ((mode < 18) ? 1 : (mode - 16)); j++) begin
            if ($urandom_range(0, 1) == 1) rp[(first + j) % 3] ^= DW'(1) << $urandom_range(0, DW - 1);
            else rf[(first + j) % 3] ^= FW'(1) << $urandom_range(0, FW - 1);
          end
        end
        step($urandom_range(0, 9) < 8, rp[0], rp[1], rp[2], rf[0], rf[1], rf[2]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
